ra_nr1w_sdr_init: RTL
=====================

// Module: ra_nr1w_sdr_init
// PURPOSE
//  Parametrised N-read/1-write SDR register-array wrapper. Generalises the fixed 2r1w 32x32 wrapper in depth, width and read-port count.
//  Adds write-to-read bypass, per-port read-valid and a post-reset zero-initialisation sweep.
//  Sits between core pipeline logic and a behavioural storage array. All ports are registered at the input.
// PARAMETERS
//  DEPTH    32  number of entries; 2..2**AWIDTH
//  AWIDTH   5   address width
//  DWIDTH   32  data width
//  NRD      2   number of read ports; 1..4
//  LATCHRD  1   1 = read data registered (latency 2); 0 = read data unregistered (latency 1)
//  BYPASS   1   1 = same-cycle write forwards to a matching read; 0 = read returns old data
//  INITZERO 1   1 = zero-fill sweep after reset; 0 = ready immediately, contents X
// PORTS
//  clk      in   1             clock
//  reset    in   1             synchronous, active-high
//  busy     out  1             init sweep in progress; all requests ignored
//  rd_enb   in   NRD           read enable; bit i = port i
//  rd_adr   in   NRD*AWIDTH    read addresses; port i = slice [i*AWIDTH +: AWIDTH]
//  rd_dat   out  NRD*DWIDTH    read data; port i = slice [i*DWIDTH +: DWIDTH]
//  rd_vld   out  NRD           rd_dat slice i is valid this cycle
//  wr_enb   in   1             write enable
//  wr_adr   in   AWIDTH        write address
//  wr_dat   in   DWIDTH        write data
// BEHAVIOUR
//  - Reset: all input regs, rd_dat and rd_vld go to 0. busy=INITZERO. FSM goes to INIT (INITZERO=1) or READY.
//  - Cycle T: request sampled into input regs (only if !busy). T+1: array read/write. rd_vld/rd_dat valid at T+1 (LATCHRD=0) or T+2 (LATCHRD=1).
//  - FSM INIT: counter 0..DEPTH-1 writes 0, one entry per cycle. At DEPTH-1: go to READY and deassert busy next cycle.
//    busy is high exactly DEPTH cycles after reset falls. READY is terminal until reset.
//  - Reset mid-sweep: counter returns to 0 and the sweep restarts. In-flight requests are dropped; rd_vld=0.
//  - While busy: rd_enb and wr_enb are treated as 0 on sampling, so no rd_vld is produced.
//  - Write: mem[wr_adr_q] <= wr_dat_q on the array cycle when wr_enb_q and wr_adr_q<DEPTH. Otherwise ignored.
//  - Read port i: rd_vld_i=1 iff rd_enb_q[i]. If rd_adr_q[i]>=DEPTH, data=0.
//  - Collision (rd_adr_q[i]==wr_adr_q, both enabled, same cycle): BYPASS=1 -> wr_dat_q; BYPASS=0 -> prior contents.
//  - Any number of read ports may hit the same address, with identical results.
//  - rd_enb=0: LATCHRD=1 holds the last rd_dat with rd_vld=0. LATCHRD=0 drives rd_dat=0.
//  - No backpressure; one read per port and one write per cycle, fully pipelined.
// TESTING
//  1 reset 1 cycle, DEPTH=32 -> busy high 32 cycles; then read all addrs -> every rd_dat=0, rd_vld=1.
//  2 write adr 5 = 0xDEADBEEF; next cycle read port0 adr 5 -> 0xDEADBEEF, vld 2 cycles after rd request (LATCHRD=1).
//  3 same cycle wr adr 7=0x12345678 and rd p0,p1 adr 7 (old 0) -> both ports 0x12345678 (BYPASS=1); 0 (BYPASS=0).
//  4 DEPTH=20: wr adr 25=0xFFFFFFFF, then read adr 25 -> 0; adrs 0..19 unchanged.
//  5 reset at sweep count 10, held 1 cycle -> busy high another 32 cycles; requests during busy -> no rd_vld, no writes.
//  6 back-to-back reads adr 0..31 on all NRD ports every cycle -> one rd_vld per port per cycle, data in issue order.

Source files
------------

// File: rtl/ra_nr1w_sdr_init.sv
// ============================================================================
// ra_nr1w_sdr_init : N-read/1-write SDR register array, optional write bypass
//                    and post-reset zero-fill sweep.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ra_nr1w_sdr_init #(
  parameter int DEPTH    = 32,
  parameter int AWIDTH   = 5,
  parameter int DWIDTH   = 32,
  parameter int NRD      = 2,
  parameter int LATCHRD  = 1,
  parameter int BYPASS   = 1,
  parameter int INITZERO = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    busy_o,
  input  logic [NRD-1:0]          rd_enb_i,
  input  logic [NRD*AWIDTH-1:0]   rd_adr_i,
  output logic [NRD*DWIDTH-1:0]   rd_dat_o,
  output logic [NRD-1:0]          rd_vld_o,
  input  logic                    wr_enb_i,
  input  logic [AWIDTH-1:0]       wr_adr_i,
  input  logic [DWIDTH-1:0]       wr_dat_i
);

  localparam int                IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AWIDTH:0]   C_DEPTH = (AWIDTH+1)'(DEPTH);
  localparam logic [IW-1:0]     C_LAST  = IW'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                  state_q;
  logic [IW-1:0]           cnt_q;
  logic                    busy_q;

  logic [NRD-1:0]          rd_enb_d;
  logic                    wr_enb_d;
  logic [NRD-1:0]          rd_enb_q;
  logic [NRD*AWIDTH-1:0]   rd_adr_q;
  logic                    wr_enb_q;
  logic [AWIDTH-1:0]       wr_adr_q;
  logic [DWIDTH-1:0]       wr_dat_q;

  logic [DWIDTH-1:0]       mem_q [DEPTH];
  logic                    w_wr_hit;

  // Requests arriving while the sweep runs are discarded at the input stage.
  assign rd_enb_d = busy_q ? '0 : rd_enb_i;
  assign wr_enb_d = busy_q ? 1'b0 : wr_enb_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_enb_q <= '0;
      rd_adr_q <= '0;
      wr_enb_q <= 1'b0;
      wr_adr_q <= '0;
      wr_dat_q <= '0;
    end else begin
      rd_enb_q <= rd_enb_d;
      rd_adr_q <= rd_adr_i;
      wr_enb_q <= wr_enb_d;
      wr_adr_q <= wr_adr_i;
      wr_dat_q <= wr_dat_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= (INITZERO != 0) ? ST_INIT : ST_READY;
      cnt_q   <= '0;
      busy_q  <= (INITZERO != 0);
    end else begin
      case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == C_LAST) begin
            state_q <= ST_READY;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end
        end
        default: busy_q <= 1'b0;
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign w_wr_hit = wr_enb_q && ({1'b0, wr_adr_q} < C_DEPTH);

  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[cnt_q] <= '0;
    end else if (w_wr_hit && !reset) begin
      mem_q[wr_adr_q[IW-1:0]] <= wr_dat_q;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AWIDTH-1:0] w_adr;
    logic              w_in_rng;
    logic              w_byp;
    logic [DWIDTH-1:0] w_dat;

    assign w_adr    = rd_adr_q[i*AWIDTH +: AWIDTH];
    assign w_in_rng = ({1'b0, w_adr} < C_DEPTH);
    assign w_byp    = (BYPASS != 0) && w_wr_hit && (w_adr == wr_adr_q);

    always_comb begin
      w_dat = '0;
      if (w_in_rng) begin
        w_dat = w_byp ? wr_dat_q : mem_q[w_adr[IW-1:0]];
      end
    end

    if (LATCHRD != 0) begin : g_latch
      logic [DWIDTH-1:0] rd_dat_q;
      logic              rd_vld_q;

      // Data register only loads on a read so idle ports hold the last result.
      always_ff @(posedge clk) begin
        if (reset) begin
          rd_dat_q <= '0;
          rd_vld_q <= 1'b0;
        end else begin
          rd_vld_q <= rd_enb_q[i];
          if (rd_enb_q[i]) begin
            rd_dat_q <= w_dat;
          end
        end
      end

      assign rd_dat_o[i*DWIDTH +: DWIDTH] = rd_dat_q;
      assign rd_vld_o[i]                  = rd_vld_q;
    end else begin : g_comb
      assign rd_dat_o[i*DWIDTH +: DWIDTH] = rd_enb_q[i] ? w_dat : '0;
      assign rd_vld_o[i]                  = rd_enb_q[i];
    end
  end

endmodule

`default_nettype wire
